// File: rtl/jtcps15_mixer_pkg.sv
// Shared constants for the CPS1.5 output volume stage: gain table, FSM encoding
// and the Q2.14 fraction width.
package jtcps15_mixer_pkg;

   localparam int FRAC_W = 14;

   // Unsigned Q2.14 gains in 2 dB steps; level 15 is unity, level 0 is mute.
   localparam logic [15:0] GAIN_TBL [0:15] = '{
      16'd0,    16'd652,  16'd821,  16'd1034,
      16'd1301, 16'd1638, 16'd2063, 16'd2597,
      16'd3269, 16'd4115, 16'd5181, 16'd6523,
      16'd8211, 16'd10338, 16'd13014, 16'd16384
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL_L = 2'd1,
      ST_MUL_R = 2'd2,
      ST_OUT   = 2'd3
   } state_t;

endpackage

// File: rtl/jtcps15_vol_ctrl.sv
// User volume control: rising-edge detection on vol_up/vol_down, saturating
// 0..15 level counter and gain table lookup.
module jtcps15_vol_ctrl
   import jtcps15_mixer_pkg::*;
#(
   parameter int VOL_INIT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vol_up,
   input  logic        vol_down,
   output logic [3:0]  level,
   output logic [15:0] gain
);

   logic up_reg;
   logic down_reg;
   logic up_rise;
   logic down_rise;

   assign up_rise   = vol_up & ~up_reg;
   assign down_rise = vol_down & ~down_reg;

   // Simultaneous up and down edges cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         up_reg   <= 1'b0;
         down_reg <= 1'b0;
         level    <= 4'(VOL_INIT);
      end else begin
         up_reg   <= vol_up;
         down_reg <= vol_down;
         if (up_rise && !down_rise && level != 4'd15)
            level <= level + 4'd1;
         else if (down_rise && !up_rise && level != 4'd0)
            level <= level - 4'd1;
      end
   end

   assign gain = GAIN_TBL[level];

endmodule

// File: rtl/jtcps15_mixer.sv
// Post-QSound volume stage: captures a stereo pair, scales both channels through
// one shared multiply-shift-saturate path, then re-strobes the saturated pair.
module jtcps15_mixer
   import jtcps15_mixer_pkg::*;
#(
   parameter int VOL_INIT = 15,
   parameter int BOOST    = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vol_up,
   input  logic               vol_down,
   input  logic               sample_in,
   input  logic signed [15:0] left_in,
   input  logic signed [15:0] right_in,
   output logic signed [15:0] left,
   output logic signed [15:0] right,
   output logic               sample,
   output logic [3:0]         vol_level,
   output logic               clip,
   output logic               overrun
);

   localparam int SHIFT = FRAC_W - BOOST;

   state_t             state_reg;
   logic signed [15:0] left_reg;
   logic signed [15:0] right_reg;
   logic [15:0]        gain_reg;
   logic signed [15:0] acc_l_reg;
   logic signed [15:0] acc_r_reg;
   logic [15:0]        level_gain;

   logic signed [32:0] op_ext;
   logic signed [32:0] gain_ext;
   logic signed [32:0] product;
   logic signed [32:0] shifted;
   logic signed [15:0] sat_val;
   logic               sat_hit;

   jtcps15_vol_ctrl #(.VOL_INIT(VOL_INIT)) u_vol (
      .clk      (clk),
      .rst      (rst),
      .vol_up   (vol_up),
      .vol_down (vol_down),
      .level    (vol_level),
      .gain     (level_gain)
   );

   // Shared datapath: the state picks which captured channel feeds the multiplier.
   always_comb begin
      op_ext   = (state_reg == ST_MUL_R) ? 33'(right_reg) : 33'(left_reg);
      gain_ext = $signed({17'd0, gain_reg});
      product  = op_ext * gain_ext;
      shifted  = product >>> SHIFT;
      sat_hit  = 1'b0;
      sat_val  = shifted[15:0];
      if (shifted > 33'sd32767) begin
         sat_hit = 1'b1;
         sat_val = 16'sh7fff;
      end else if (shifted < -33'sd32768) begin
         sat_hit = 1'b1;
         sat_val = 16'sh8000;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         left_reg  <= '0;
         right_reg <= '0;
         gain_reg  <= '0;
         acc_l_reg <= '0;
         acc_r_reg <= '0;
         left      <= '0;
         right     <= '0;
         sample    <= 1'b0;
         clip      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         sample <= 1'b0;
         if (sample_in && state_reg != ST_IDLE)
            overrun <= 1'b1;
         case (state_reg)
            ST_IDLE: begin
               if (sample_in) begin
                  left_reg  <= left_in;
                  right_reg <= right_in;
                  gain_reg  <= level_gain;
                  state_reg <= ST_MUL_L;
               end
            end
            ST_MUL_L: begin
               acc_l_reg <= sat_val;
               if (sat_hit) clip <= 1'b1;
               state_reg <= ST_MUL_R;
            end
            ST_MUL_R: begin
               acc_r_reg <= sat_val;
               if (sat_hit) clip <= 1'b1;
               state_reg <= ST_OUT;
            end
            default: begin
               left      <= acc_l_reg;
               right     <= acc_r_reg;
               sample    <= 1'b1;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jtcps15_mixer.sv
// Bench for jtcps15_mixer: two instances (BOOST 0 and 1) share stimulus and are
// compared every cycle against a transaction-level model of the volume stage.
module tb_jtcps15_mixer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vol_up = 1'b0;
   logic vol_down = 1'b0;
   logic sample_in = 1'b0;
   logic signed [15:0] left_in = '0;
   logic signed [15:0] right_in = '0;

   logic signed [15:0] l0, r0, l1, r1;
   logic s0, s1, c0, c1, o0, o1;
   logic [3:0] v0, v1;

   always #5 clk = ~clk;

   jtcps15_mixer #(.VOL_INIT(15), .BOOST(0)) dut0 (
      .clk(clk), .rst(rst), .vol_up(vol_up), .vol_down(vol_down),
      .sample_in(sample_in), .left_in(left_in), .right_in(right_in),
      .left(l0), .right(r0), .sample(s0), .vol_level(v0), .clip(c0), .overrun(o0)
   );

   jtcps15_mixer #(.VOL_INIT(15), .BOOST(1)) dut1 (
      .clk(clk), .rst(rst), .vol_up(vol_up), .vol_down(vol_down),
      .sample_in(sample_in), .left_in(left_in), .right_in(right_in),
      .left(l1), .right(r1), .sample(s1), .vol_level(v1), .clip(c1), .overrun(o1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (iter %0d)", tag, got, exp, it);
      end
   endtask

   // Reference model state.
   int gain_tab [16] = '{0, 652, 821, 1034, 1301, 1638, 2063, 2597,
                         3269, 4115, 5181, 6523, 8211, 10338, 13014, 16384};
   typedef struct {
      int due;
      int l0, r0, l1, r1;
      bit clip0, clip1;
   } pair_t;
   pair_t exp_q[$];
   int  it = 0;
   int  lvl_m = 15;
   int  next_free = 0;
   bit  pu = 0, pd = 0;
   bit  ov_m = 0;
   bit  clip_m0 = 0, clip_m1 = 0;
   int  last_l0 = 0, last_r0 = 0, last_l1 = 0, last_r1 = 0;

   // x * g / 2^(14-boost), floored, then clamped to the 16-bit signed range.
   function automatic int scale(input int x, input int g, input int boost, output bit sat);
      longint p, d, q;
      p = longint'(x) * longint'(g);
      d = longint'(1) << (14 - boost);
      q = p / d;
      if (p < 0 && (p % d) != 0) q = q - 1;
      sat = 1'b0;
      if (q > 32767) begin q = 32767; sat = 1'b1; end
      if (q < -32768) begin q = -32768; sat = 1'b1; end
      return int'(q);
   endfunction

   task automatic tick(input bit rs, input bit sin, input int li, input int ri,
                       input bit up, input bit dn);
      pair_t e;
      bit ur, dr;
      @(negedge clk);
      rst = rs; sample_in = sin; vol_up = up; vol_down = dn;
      left_in = li[15:0]; right_in = ri[15:0];
      @(posedge clk);
      if (rs) begin
         exp_q.delete();
         lvl_m = 15; pu = 0; pd = 0; ov_m = 0; clip_m0 = 0; clip_m1 = 0;
         last_l0 = 0; last_r0 = 0; last_l1 = 0; last_r1 = 0;
         next_free = it + 1;
      end else begin
         if (sin) begin
            if (it >= next_free) begin
               e.due = it + 3;
               e.l0 = scale(li, gain_tab[lvl_m], 0, e.clip0);
               e.r0 = scale(ri, gain_tab[lvl_m], 0, ur);
               e.clip0 |= ur;
               e.l1 = scale(li, gain_tab[lvl_m], 1, e.clip1);
               e.r1 = scale(ri, gain_tab[lvl_m], 1, ur);
               e.clip1 |= ur;
               exp_q.push_back(e);
               next_free = it + 4;
            end else begin
               ov_m = 1;
            end
         end
         ur = up && !pu;
         dr = dn && !pd;
         if (ur && !dr && lvl_m < 15) lvl_m++;
         else if (dr && !ur && lvl_m > 0) lvl_m--;
         pu = up; pd = dn;
      end
      #1;
      chk("level0", int'(v0), lvl_m);
      chk("level1", int'(v1), lvl_m);
      chk("overrun0", int'(o0), int'(ov_m));
      chk("overrun1", int'(o1), int'(ov_m));
      if (exp_q.size() > 0 && exp_q[0].due == it) begin
         e = exp_q.pop_front();
         last_l0 = e.l0; last_r0 = e.r0; last_l1 = e.l1; last_r1 = e.r1;
         clip_m0 |= e.clip0;
         clip_m1 |= e.clip1;
         chk("strobe0", int'(s0), 1);
         chk("strobe1", int'(s1), 1);
         chk("clip0", int'(c0), int'(clip_m0));
         chk("clip1", int'(c1), int'(clip_m1));
      end else begin
         chk("strobe0", int'(s0), 0);
         chk("strobe1", int'(s1), 0);
      end
      chk("left0", int'(l0), last_l0);
      chk("right0", int'(r0), last_r0);
      chk("left1", int'(l1), last_l1);
      chk("right1", int'(r1), last_r1);
      it++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
   endtask

   task automatic pulse_vol(input bit up, input int n);
      for (int i = 0; i < n; i++) begin
         tick(0, 0, 0, 0, up, !up);
         tick(0, 0, 0, 0, 0, 0);
      end
   endtask

   function automatic int rand16();
      logic [15:0] rv;
      rv = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rv = ($urandom_range(0, 1) != 0) ? 16'h7fff : 16'h8000;
      return int'($signed(rv));
   endfunction

   initial begin
      bit up_h, dn_h;
      tick(1, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0);
      chk("reset_level", int'(v0), 15);
      chk("reset_clip", int'(c0), 0);
      chk("reset_overrun", int'(o0), 0);

      // Unity gain pass-through.
      tick(0, 1, 1000, -1000, 0, 0);
      idle(4);
      chk("unity_left", int'(l0), 1000);
      chk("unity_right", int'(r0), -1000);
      chk("unity_clip", int'(c0), 0);

      // Three steps down to level 12.
      pulse_vol(0, 3);
      chk("level12", int'(v0), 12);
      tick(0, 1, 16384, -16384, 0, 0);
      idle(4);
      chk("l12_left", int'(l0), 8211);
      chk("l12_right", int'(r0), -8211);

      // Back to 15; BOOST=1 instance saturates.
      pulse_vol(1, 3);
      tick(0, 1, 20000, -20000, 0, 0);
      idle(4);
      chk("boost_left", int'(l1), 32767);
      chk("boost_right", int'(r1), -32768);
      chk("boost_clip", int'(c1), 1);
      chk("noboost_left", int'(l0), 20000);
      idle(3);
      chk("clip_sticky", int'(c1), 1);

      // Saturation of the level counter and simultaneous edges.
      pulse_vol(1, 1);
      chk("sat_top", int'(v0), 15);
      tick(0, 0, 0, 0, 1, 1);
      tick(0, 0, 0, 0, 0, 0);
      chk("both_edges", int'(v0), 15);
      pulse_vol(0, 16);
      chk("sat_bottom", int'(v0), 0);
      tick(0, 1, 12345, 12345, 0, 0);
      idle(4);
      chk("mute_left", int'(l0), 0);
      chk("mute_right1", int'(r1), 0);

      // Overrun: second pair dropped; gain change mid-flight ignored.
      pulse_vol(1, 10);
      tick(0, 1, 500, -700, 0, 0);
      tick(0, 0, 0, 0, 0, 1);
      tick(0, 1, 9999, 9999, 0, 0);
      idle(4);
      chk("ovr_flag", int'(o0), 1);
      chk("ovr_left", int'(l0), 158);
      chk("ovr_right", int'(r0), -222);
      chk("ovr_level", int'(v0), 9);

      // Reset while the right channel is being computed.
      tick(0, 1, 3000, 3000, 0, 0);
      tick(0, 0, 0, 0, 0, 0);
      tick(1, 0, 0, 0, 0, 0);
      chk("rst_left", int'(l0), 0);
      chk("rst_level", int'(v0), 15);
      chk("rst_overrun", int'(o0), 0);
      chk("rst_clip", int'(c1), 0);
      idle(6);

      // Randomized traffic.
      up_h = 0; dn_h = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) up_h = !up_h;
         if ($urandom_range(0, 7) == 0) dn_h = !dn_h;
         tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 2) == 0),
              rand16(), rand16(), up_h, dn_h);
      end
      idle(6);
      chk("final_clip0", int'(c0), int'(clip_m0));
      chk("final_clip1", int'(c1), int'(clip_m1));
      chk("final_queue", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
